// File: rtl/hex_pkg.sv
// Shared definitions for the Hex memory arbiter slice.
//   HEX_WORD_WIDTH : native Hex word width
//   REQ_*          : fixed requester slots on the arbiter
//   hex_word_t     : one Hex word
//   rr_next        : round-robin successor of a granted index
package hex_pkg;

   localparam int HEX_WORD_WIDTH = 32;

   localparam int REQ_IFETCH = 0;
   localparam int REQ_DATA   = 1;
   localparam int REQ_HOST   = 2;

   typedef logic [HEX_WORD_WIDTH-1:0] hex_word_t;

   function automatic int rr_next(input int g, input int n);
      return (g == n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/hex_mem_arbiter_if.sv
// Bus bundle between the requesters/memory macro and hex_mem_arbiter.
//   i_req/i_we/i_addr/i_wdata : per-requester command, held until o_gnt
//   o_gnt/o_rvalid/o_rdata    : grant and routed read return
//   o_mem_*/i_mem_rdata       : single-port memory macro side
//   o_busy                    : a read is in flight
// Modports: slave = arbiter, master = requesters plus memory macro.
interface hex_mem_arbiter_if
   import hex_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = HEX_WORD_WIDTH
);

   logic [NUM_REQ-1:0]                 i_req;
   logic [NUM_REQ-1:0]                 i_we;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] i_addr;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_wdata;
   logic [NUM_REQ-1:0]                 o_gnt;
   logic [NUM_REQ-1:0]                 o_rvalid;
   logic [DATA_WIDTH-1:0]              o_rdata;
   logic                               o_mem_en;
   logic                               o_mem_we;
   logic [ADDR_WIDTH-1:0]              o_mem_addr;
   logic [DATA_WIDTH-1:0]              o_mem_wdata;
   logic [DATA_WIDTH-1:0]              i_mem_rdata;
   logic                               o_busy;

   modport slave (
      input  i_req, i_we, i_addr, i_wdata, i_mem_rdata,
      output o_gnt, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr,
             o_mem_wdata, o_busy
   );

   modport master (
      output i_req, i_we, i_addr, i_wdata, i_mem_rdata,
      input  o_gnt, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr,
             o_mem_wdata, o_busy
   );

endinterface

// File: rtl/hex_rr_arbiter.sv
// Work-conserving round-robin arbiter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_req[N]       : request vector
//   o_gnt[N]       : one-hot grant, combinational from i_req and ptr
// Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1; ptr moves to one past
// the granted index and holds when nothing is granted.
module hex_rr_arbiter
   import hex_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic [N-1:0]  lo_mask;
   logic [N-1:0]  req_hi;
   logic [N-1:0]  req_sel;

   // Requests at or above ptr win first; if none, fall back to the full
   // vector so the wrap-around portion is considered. The lowest set bit of
   // the chosen vector is isolated with x & -x.
   always_comb begin
      lo_mask = (N'(1) << ptr) - N'(1);
      req_hi  = i_req & ~lo_mask;
      req_sel = (|req_hi) ? req_hi : i_req;
      o_gnt   = i_rst_n ? (req_sel & (-req_sel)) : '0;
   end

   always_comb begin
      ptr_nxt = ptr;
      for (int k = 0; k < N; k++) begin
         if (o_gnt[k]) begin
            ptr_nxt = PW'(rr_next(k, N));
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/hex_mem_arbiter.sv
// Shares the single-port Hex main memory between ifetch, data and host.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : requester commands in, grant/read return out,
//                    memory macro command out, memory read data in
// One command per cycle, muxed combinationally from the granted requester.
// Reads are tracked in a MEM_LATENCY-deep pipe of {valid, id} so the
// returning word is steered to the requester that issued it.
module hex_mem_arbiter
   import hex_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = HEX_WORD_WIDTH,
   parameter int MEM_LATENCY = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   hex_mem_arbiter_if.slave bus
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]                  gnt;
   logic [ID_W-1:0]                     gnt_id;
   logic                                mem_we;
   logic [ADDR_WIDTH-1:0]               mem_addr;
   logic [DATA_WIDTH-1:0]               mem_wdata;
   logic [MEM_LATENCY-1:0]              pipe_vld;
   logic [MEM_LATENCY-1:0][ID_W-1:0]    pipe_id;

   hex_rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (bus.i_req),
      .o_gnt   (gnt)
   );

   // gnt is one-hot or zero, so at most one iteration fires.
   always_comb begin
      gnt_id    = '0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            gnt_id    = ID_W'(k);
            mem_we    = bus.i_we[k];
            mem_addr  = bus.i_addr[k];
            mem_wdata = bus.i_wdata[k];
         end
      end
   end

   // Writes enter the pipe as invalid slots so the tail stays aligned with
   // the memory latency regardless of the command mix.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pipe_vld <= '0;
         pipe_id  <= '0;
      end else begin
         pipe_vld[0] <= (|gnt) & ~mem_we;
         pipe_id[0]  <= gnt_id;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_id[i]  <= pipe_id[i-1];
         end
      end
   end

   assign bus.o_gnt       = gnt;
   assign bus.o_mem_en    = |gnt;
   assign bus.o_mem_we    = mem_we;
   assign bus.o_mem_addr  = mem_addr;
   assign bus.o_mem_wdata = mem_wdata;
   assign bus.o_rvalid    = pipe_vld[MEM_LATENCY-1]
                            ? (NUM_REQ'(1) << pipe_id[MEM_LATENCY-1]) : '0;
   assign bus.o_rdata     = bus.i_mem_rdata;
   assign bus.o_busy      = |pipe_vld;

endmodule

// File: tb/tb_hex_mem_arbiter.sv
module tb_hex_mem_arbiter;
   import hex_pkg::*;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = HEX_WORD_WIDTH;
   localparam int L  = 3;
   localparam int MW = 64;

   typedef struct {
      logic           we;
      logic [AW-1:0]  addr;
      hex_word_t      wdata;
   } cmd_t;

   typedef struct {
      int        id;
      hex_word_t data;
      int        due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hex_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   hex_mem_arbiter #(
      .NUM_REQ     (N),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .MEM_LATENCY (L)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   cmd_t       pq[N][$];
   exp_t       sb[$];
   hex_word_t  mem_mac[MW];
   hex_word_t  mem_ref[MW];
   hex_word_t  mpipe[L];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [N-1:0] gnt_seen = '0;

   function automatic hex_word_t init_word(input int a);
      return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0101);
   endfunction

   function automatic cmd_t mk(input logic we, input int addr, input hex_word_t wd);
      cmd_t c;
      c.we = we;
      c.addr = AW'(addr);
      c.wdata = wd;
      return c;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory macro: command sampled mid-cycle, applied at the edge, read data
   // appears L cycles after the command cycle.
   initial begin
      logic en, we;
      int a;
      hex_word_t wd;
      for (int i = 0; i < MW; i++) mem_mac[i] = init_word(i);
      for (int i = 0; i < L; i++) mpipe[i] = '0;
      bus.i_mem_rdata = '0;
      forever begin
         @(negedge clk);
         en = bus.o_mem_en;
         we = bus.o_mem_we;
         a  = int'(bus.o_mem_addr) % MW;
         wd = bus.o_mem_wdata;
         @(posedge clk);
         for (int i = L - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
         mpipe[0] = (en && !we) ? mem_mac[a] : '0;
         if (en && we) mem_mac[a] = wd;
         bus.i_mem_rdata = mpipe[L-1];
      end
   end

   // Requester driver: presents queued commands, holds each until granted.
   initial begin
      cmd_t c;
      bus.i_req = '0;
      bus.i_we = '0;
      bus.i_addr = '0;
      bus.i_wdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            bus.i_req = '0;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (bus.i_req[k] && gnt_seen[k]) bus.i_req[k] = 1'b0;
               if (!bus.i_req[k] && pq[k].size() > 0) begin
                  c = pq[k].pop_front();
                  bus.i_req[k]   = 1'b1;
                  bus.i_we[k]    = c.we;
                  bus.i_addr[k]  = c.addr;
                  bus.i_wdata[k] = c.wdata;
               end
            end
         end
      end
   end

   // Reference model: round-robin search from a pointer, memory contents as
   // an array, expected read returns pushed into the scoreboard.
   initial begin
      int ptr_m;
      int g;
      int idx;
      logic [N-1:0] eg;
      logic ewe;
      logic [AW-1:0] ea;
      hex_word_t ed;
      logic p_rst;
      logic [N-1:0] p_req, p_gnt;
      cmd_t p_cmd[N];
      exp_t e;
      ptr_m = 0;
      p_rst = 1'b0;
      p_req = '0;
      p_gnt = '0;
      for (int i = 0; i < MW; i++) mem_ref[i] = init_word(i);
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_ctrl", 64'({bus.o_gnt, bus.o_rvalid, bus.o_mem_en, bus.o_mem_we, bus.o_busy}), 64'(0));
            chk("rst_cmd", 64'({bus.o_mem_addr, bus.o_mem_wdata}), 64'(0));
            sb.delete();
            ptr_m = 0;
            gnt_seen = '0;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (p_rst && p_req[k] && !p_gnt[k]) begin
                  assert (bus.i_req[k] && bus.i_we[k] == p_cmd[k].we &&
                          bus.i_addr[k] == p_cmd[k].addr && bus.i_wdata[k] == p_cmd[k].wdata)
                     else $error("request %0d dropped or changed before grant", k);
               end
            end
            g = -1;
            for (int i = 0; i < N; i++) begin
               idx = (ptr_m + i) % N;
               if (g < 0 && bus.i_req[idx]) g = idx;
            end
            eg = '0;
            ewe = 1'b0;
            ea = '0;
            ed = '0;
            if (g >= 0) begin
               eg[g] = 1'b1;
               ewe = bus.i_we[g];
               ea = bus.i_addr[g];
               ed = bus.i_wdata[g];
            end
            chk("gnt", 64'(bus.o_gnt), 64'(eg));
            chk("mem_en", 64'(bus.o_mem_en), 64'(g >= 0));
            chk("mem_cmd", 64'({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata}), 64'({ewe, ea, ed}));
            gnt_seen = bus.o_gnt;
            if (g >= 0) begin
               ptr_m = (g + 1) % N;
               if (ewe) begin
                  mem_ref[int'(ea) % MW] = ed;
               end else begin
                  e.id = g;
                  e.data = mem_ref[int'(ea) % MW];
                  e.due = cyc + L;
                  sb.push_back(e);
               end
            end
         end
         p_rst = rst_n;
         p_req = bus.i_req;
         p_gnt = bus.o_gnt;
         for (int k = 0; k < N; k++) p_cmd[k] = mk(bus.i_we[k], int'(bus.i_addr[k]), bus.i_wdata[k]);
      end
   end

   // Monitor: pops the scoreboard whenever the DUT returns read data.
   initial begin
      logic eb;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            eb = 1'b0;
            foreach (sb[i]) if (sb[i].due <= cyc + L - 1) eb = 1'b1;
            chk("busy", 64'(bus.o_busy), 64'(eb));
            if (bus.o_rvalid != '0) begin
               if (sb.size() == 0) begin
                  chk("rvalid_extra", 64'(bus.o_rvalid), 64'(0));
               end else begin
                  e = sb.pop_front();
                  chk("rvalid_id", 64'(bus.o_rvalid), 64'(1) << e.id);
                  chk("rdata", 64'(bus.o_rdata), 64'(e.data));
                  chk("rvalid_lat", 64'(cyc), 64'(e.due));
               end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
               e = sb.pop_front();
               chk("rvalid_missing", 64'(bus.o_rvalid), 64'(1) << e.id);
            end
         end
      end
   end

   task automatic drain();
      int n;
      int pend;
      n = 0;
      forever begin
         @(posedge clk);
         #2;
         pend = 0;
         for (int k = 0; k < N; k++) pend += pq[k].size();
         if (pend == 0 && bus.i_req == '0 && sb.size() == 0) break;
         n++;
         if (n > 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d req=%0h sb=%0d", pend, bus.i_req, sb.size());
            break;
         end
      end
   endtask

   task automatic wait_gnt(input int k);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.o_gnt[k]) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL gnt_timeout requester=%0d got=0 expected=1", k);
      end
   endtask

   initial begin
      cmd_t c;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // all three requesting continuously: strict rotation from ptr=0
      for (int k = 0; k < N; k++) begin
         pq[k].push_back(mk(1'b0, 20 + k, '0));
         pq[k].push_back(mk(1'b0, 30 + k, '0));
      end
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_seq", 64'(bus.o_gnt), 64'(1) << (i % 3));
         chk("rr_mem_en", 64'(bus.o_mem_en), 64'(1));
      end
      drain();

      // host write then ifetch read of the same word
      pq[REQ_HOST].push_back(mk(1'b1, 16, 32'hDEAD_BEEF));
      drain();
      pq[REQ_IFETCH].push_back(mk(1'b0, 16, '0));
      wait_gnt(REQ_IFETCH);
      repeat (L) @(negedge clk);
      chk("wr_rd_rvalid", 64'(bus.o_rvalid), 64'(3'b001));
      chk("wr_rd_rdata", 64'(bus.o_rdata), 64'(32'hDEAD_BEEF));
      drain();

      // data port streaming four reads back to back
      for (int a = 0; a < 4; a++) pq[REQ_DATA].push_back(mk(1'b0, a, '0));
      @(posedge clk);
      for (int i = 0; i < 4 + L; i++) begin
         @(negedge clk);
         if (i < 4) chk("stream_gnt", 64'(bus.o_gnt), 64'(3'b010));
         if (i >= L) begin
            chk("stream_rvalid", 64'(bus.o_rvalid), 64'(3'b010));
            chk("stream_rdata", 64'(bus.o_rdata), 64'(init_word(i - L)));
         end
      end
      drain();

      // pointer sits at 2: requests 0 and 1 wrap to 0 first
      pq[REQ_IFETCH].push_back(mk(1'b0, 5, '0));
      pq[REQ_DATA].push_back(mk(1'b0, 6, '0));
      @(posedge clk);
      @(negedge clk);
      chk("wrap_gnt0", 64'(bus.o_gnt), 64'(3'b001));
      @(negedge clk);
      chk("wrap_gnt1", 64'(bus.o_gnt), 64'(3'b010));
      drain();

      // reset while two reads are in flight
      pq[REQ_IFETCH].push_back(mk(1'b0, 7, '0));
      pq[REQ_DATA].push_back(mk(1'b0, 8, '0));
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_flush_rvalid", 64'(bus.o_rvalid), 64'(0));
         chk("rst_flush_busy", 64'(bus.o_busy), 64'(0));
      end
      drain();

      // idle, then a lone request is granted immediately
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_gnt", 64'(bus.o_gnt), 64'(0));
         chk("idle_mem_en", 64'(bus.o_mem_en), 64'(0));
      end
      @(posedge clk);
      #2 pq[REQ_HOST].push_back(mk(1'b0, 9, '0));
      @(posedge clk);
      @(negedge clk);
      chk("lone_gnt", 64'(bus.o_gnt), 64'(3'b100));
      drain();

      // random mix of reads and writes from all requesters
      repeat (3000) begin
         @(posedge clk);
         #2;
         for (int k = 0; k < N; k++) begin
            if (pq[k].size() < 2 && $urandom_range(0, 2) == 0) begin
               c = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, MW - 1)), $urandom);
               pq[k].push_back(c);
            end
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
